sensor_fifo: RTL and testbench
==============================

SENSOR_FIFO -- requirements
Module: sensor_fifo

Interface
REQ-001 Parameter WIDTH, default 3, data word width in bits (bench packs {rs2,rs1,rs}).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, minimum 4.
REQ-003 Parameter AFULL_TH, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 Parameter CHG_ONLY, default 0; when 1, a write is accepted only if din differs from the last accepted word.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  write request; samples din this cycle.
REQ-008 din  input  WIDTH  write data.
REQ-009 rd  input  1  read request; level-sensitive, one word per cycle while high and not empty.
REQ-010 flush  input  1  synchronous clear of contents and sticky flags.
REQ-011 dout  output  WIDTH  read data, registered.
REQ-012 valid  output  1  high for one cycle when dout holds a newly read word.
REQ-013 full, empty, almost_full  output  1 each  occupancy flags.
REQ-014 count  output  $clog2(DEPTH)+1  current number of stored words.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Read latency is 1 cycle: rd accepted at edge N gives dout/valid at edge N+1; dout holds its value otherwise.
REQ-017 Write is accepted when enable=1, and not full or rd accepted this same cycle, and (CHG_ONLY=0 or din differs from last accepted word or FIFO has never accepted a word since reset/flush).
REQ-018 Read is accepted when rd=1 and empty=0.
REQ-019 count increments on write-only, decrements on read-only, unchanged on simultaneous write+read.
REQ-020 Full with simultaneous enable+rd: both accepted, count stays DEPTH, no overflow.
REQ-021 Empty with simultaneous enable+rd: write accepted, read rejected, underflow set, count becomes 1.
REQ-022 enable=1 while full and no accepted read: word dropped, overflow set, contents unchanged.
REQ-023 rd=1 while empty (without the REQ-021 case): no read, valid=0, underflow set.
REQ-024 A write rejected by CHG_ONLY filtering is not an error and sets no flag.
REQ-025 Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_TH), all derived combinationally from registered count.
REQ-027 flush has priority over enable and rd: next cycle count=0, pointers=0, overflow=underflow=0, valid=0, CHG_ONLY history cleared; dout retains value.
REQ-028 overflow and underflow remain set until reset or flush.

Reset
REQ-029 reset asserted at any time, including mid-read or mid-write, immediately forces count=0, pointers=0, dout=0, valid=0, overflow=0, underflow=0, CHG_ONLY history cleared.
REQ-030 After reset deassertion, empty=1, full=0, almost_full=0 (AFULL_TH>0); first operation accepted on the next rising edge.
REQ-031 Storage array contents need not be reset.

Structure
REQ-032 Shared package/include sensor_fifo_pkg holds default WIDTH, DEPTH, AFULL_TH constants and the count-width function.
REQ-033 Storage shall be a sub-module fifo_ram: DEPTH x WIDTH, one synchronous write port, one registered read port; pointer, count, and flag logic stays in sensor_fifo.

Verification (WIDTH=3, DEPTH=8, AFULL_TH=6 unless noted)
REQ-034 Reset, then write 3'b001..3'b111 and 3'b000 (8 words), then rd held 8 cycles -> dout sequence 1..7,0, each with valid=1 one cycle after rd; full=1 after 8th write; empty=1 after last read.
REQ-035 Fill to 8, assert enable with din=5 -> overflow=1, count=8; then enable+rd same cycle -> count=8, overflow still 1, word 5 read out last.
REQ-036 Empty FIFO, rd=1 one cycle -> underflow=1, valid=0; empty FIFO, enable+rd with din=3 -> count=1, underflow=1, next rd returns 3.
REQ-037 CHG_ONLY=1, din held at 3'b111 for 10 enable cycles, then 3'b000 -> count=2; reads return 7 then 0.
REQ-038 Write 4 words, pulse reset mid-read -> outputs at reset values without waiting for a clock edge; write after deassertion lands at entry 0.
REQ-039 Write 6 words -> almost_full=1 at count=6; flush with enable+rd also high -> count=0, flags cleared, no word written.

Source files
------------

// File: rtl/sensor_fifo_pkg.sv
// Shared defaults and sizing helper for the sensor FIFO and its storage.
package sensor_fifo_pkg;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AFULL_TH = DEF_DEPTH - 2;

  // Occupancy counter must hold the value DEPTH itself, hence one extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, registered read port.
module fifo_ram
  import sensor_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register; a same-address write in this cycle returns the old word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= {WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sensor_fifo.sv
// Sensor sample FIFO: pointers, occupancy, sticky error flags and optional change-only filtering.
module sensor_fifo
  import sensor_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AFULL_TH = DEPTH - 2,
  parameter bit CHG_ONLY = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [WIDTH-1:0]              din,
  input  logic                          rd,
  input  logic                          flush,
  output logic [WIDTH-1:0]              dout,
  output logic                          valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFTH_C  = CW'(AFULL_TH);

  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, valid_q, valid_d;
  logic             hist_q, hist_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             rd_ok_s, chg_ok_s, wr_ok_s, ram_we_s, ram_re_s;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == {CW{1'b0}});
  assign almost_full = (count_q >= AFTH_C);

  // Acceptance decisions and next-state; flush overrides every request.
  always_comb begin
    rd_ok_s  = rd && !empty;
    chg_ok_s = !CHG_ONLY || !hist_q || (din != last_q);
    wr_ok_s  = enable && (!full || rd_ok_s) && chg_ok_s;
    ram_we_s = 1'b0;
    ram_re_s = 1'b0;
    count_d  = count_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    valid_d  = 1'b0;
    hist_d   = hist_q;
    last_d   = last_q;
    if (flush) begin
      count_d = {CW{1'b0}};
      wptr_d  = {AW{1'b0}};
      rptr_d  = {AW{1'b0}};
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      hist_d  = 1'b0;
    end else begin
      ram_we_s = wr_ok_s;
      ram_re_s = rd_ok_s;
      valid_d  = rd_ok_s;
      // A change-filtered write while full is not counted as an overflow.
      ovf_d    = ovf_q || (enable && full && !rd_ok_s && chg_ok_s);
      unf_d    = unf_q || (rd && empty);
      if (wr_ok_s) begin
        wptr_d = wptr_q + AW'(1);
        hist_d = 1'b1;
        last_d = din;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_ok_s) begin
        rptr_d = rptr_q + AW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CW{1'b0}};
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
      hist_q  <= 1'b0;
      last_q  <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
      hist_q  <= hist_d;
      last_q  <= last_d;
    end
  end

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (ram_we_s),
    .waddr_i (wptr_q),
    .wdata_i (din),
    .re_i    (ram_re_s),
    .raddr_i (rptr_q),
    .rdata_o (dout)
  );

  assign valid     = valid_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sensor_fifo.sv
// Scoreboard bench for sensor_fifo (DEPTH=8, AFULL_TH=6) plus a CHG_ONLY instance.
module tb_sensor_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, rd = 1'b0, flush = 1'b0;
  logic [2:0] din = 3'd0;
  logic [2:0] dout;
  logic       valid, full, empty, almost_full, overflow, underflow;
  logic [3:0] count;

  logic       b_enable = 1'b0, b_rd = 1'b0, b_flush = 1'b0;
  logic [2:0] b_din = 3'd0;
  logic [2:0] b_dout;
  logic       b_valid, b_full, b_empty, b_almost_full, b_overflow, b_underflow;
  logic [3:0] b_count;

  int errors = 0;
  int checks = 0;

  logic [2:0] mq[$];
  logic [2:0] bq[$];
  logic       mov = 1'b0, mun = 1'b0, exp_valid = 1'b0;
  logic [2:0] exp_dout = 3'd0;

  always #5 clk = ~clk;

  sensor_fifo #(.WIDTH(3), .DEPTH(8), .AFULL_TH(6), .CHG_ONLY(1'b0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .din(din), .rd(rd), .flush(flush),
    .dout(dout), .valid(valid), .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sensor_fifo #(.WIDTH(3), .DEPTH(8), .AFULL_TH(6), .CHG_ONLY(1'b1)) dut_b (
    .clk(clk), .reset(reset), .enable(b_enable), .din(b_din), .rd(b_rd), .flush(b_flush),
    .dout(b_dout), .valid(b_valid), .full(b_full), .empty(b_empty), .almost_full(b_almost_full),
    .count(b_count), .overflow(b_overflow), .underflow(b_underflow)
  );

  // One clock of stimulus on dut_a; the model predicts acceptance and pops the scoreboard on reads.
  task automatic step(input logic en, input logic [2:0] d, input logic r, input logic fl);
    logic rd_ok;
    @(negedge clk);
    enable = en; din = d; rd = r; flush = fl;
    exp_valid = 1'b0;
    if (fl) begin
      mq.delete();
      mov = 1'b0;
      mun = 1'b0;
    end else begin
      rd_ok = r && (mq.size() != 0);
      if (r && mq.size() == 0) mun = 1'b1;
      if (en && mq.size() == 8 && !rd_ok) mov = 1'b1;
      if (rd_ok) begin
        exp_dout  = mq.pop_front();
        exp_valid = 1'b1;
      end
      if (en && mq.size() < 8) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    enable = 1'b0; rd = 1'b0; flush = 1'b0;
    checks++; if (valid !== exp_valid) begin errors++; $display("FAIL valid: got %b exp %b", valid, exp_valid); end
    checks++; if (dout !== exp_dout) begin errors++; $display("FAIL dout: got %0d exp %0d", dout, exp_dout); end
    checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL count: got %0d exp %0d", count, mq.size()); end
    checks++; if (full !== (mq.size() == 8)) begin errors++; $display("FAIL full: got %b cnt %0d", full, mq.size()); end
    checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL empty: got %b cnt %0d", empty, mq.size()); end
    checks++; if (almost_full !== (mq.size() >= 6)) begin errors++; $display("FAIL almost_full: got %b cnt %0d", almost_full, mq.size()); end
    checks++; if (overflow !== mov) begin errors++; $display("FAIL overflow: got %b exp %b", overflow, mov); end
    checks++; if (underflow !== mun) begin errors++; $display("FAIL underflow: got %b exp %b", underflow, mun); end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
    checks++; if ({empty, full, almost_full} !== 3'b100) begin errors++; $display("FAIL rst_flags: got %b exp 100", {empty, full, almost_full}); end
    checks++; if ({valid, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL rst_vou: got %b exp 000", {valid, overflow, underflow}); end
    checks++; if (dout !== 3'd0) begin errors++; $display("FAIL rst_dout: got %0d exp 0", dout); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) step(1'b1, 3'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i + 2), 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 1'b1, 1'b0);
    checks++; if (exp_dout !== 3'd5 || dout !== 3'd5) begin errors++; $display("FAIL ovf_last: got %0d exp 5", dout); end
    step(1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_underflow();
    step(1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd3, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_chg_only();
    logic [2:0] last = 3'd0;
    logic       hist = 1'b0;
    logic [2:0] v;
    for (int i = 0; i < 11; i++) begin
      v = (i < 10) ? 3'd7 : 3'd0;
      @(negedge clk);
      b_enable = 1'b1; b_din = v;
      if (!hist || v != last) bq.push_back(v);
      hist = 1'b1; last = v;
      @(posedge clk); #1;
      b_enable = 1'b0;
    end
    checks++; if (b_count !== 4'(bq.size())) begin errors++; $display("FAIL chg_count: got %0d exp %0d", b_count, bq.size()); end
    checks++; if (b_overflow !== 1'b0) begin errors++; $display("FAIL chg_ovf: got %b exp 0", b_overflow); end
    while (bq.size() != 0) begin
      v = bq.pop_front();
      @(negedge clk); b_rd = 1'b1;
      @(posedge clk); #1; b_rd = 1'b0;
      checks++; if (b_valid !== 1'b1 || b_dout !== v) begin errors++; $display("FAIL chg_read: got v=%b d=%0d exp v=1 d=%0d", b_valid, b_dout, v); end
    end
    checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL chg_empty: got %b exp 1", b_empty); end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 1; i <= 4; i++) step(1'b1, 3'(i), 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    #2; reset = 1'b1; #1;
    mq.delete(); mov = 1'b0; mun = 1'b0; exp_dout = 3'd0;
    checks++; if ({valid, dout} !== 4'b0000) begin errors++; $display("FAIL async_rst_out: got v=%b d=%0d exp 0/0", valid, dout); end
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL async_rst_cnt: got %0d exp 0", count); end
    @(negedge clk); reset = 1'b0;
    step(1'b1, 3'd6, 1'b0, 1'b0);
    checks++; if (dut_a.u_ram.mem_q[0] !== 3'd6) begin errors++; $display("FAIL entry0: got %0d exp 6", dut_a.u_ram.mem_q[0]); end
    step(1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_almost_full_flush();
    for (int i = 0; i < 6; i++) step(1'b1, 3'(7 - i), 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b1, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_chg_only();
    test_reset_mid_read();
    test_almost_full_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
